// File: rtl/axil_lite_master_if.sv
// rtl/axil_lite_master_if.sv - AXI4-Lite bus bundle with master and slave views
interface axil_lite_master_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axil_lite_master.sv
// rtl/axil_lite_master.sv - single-outstanding AXI4-Lite initiator driven by a cmd/rsp stream
module axil_lite_master #(
    parameter int         ADDR_WIDTH = 9,
    parameter int         DATA_WIDTH = 32,
    parameter int         STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic                  busy,

    axil_lite_master_if.master    m_axil
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

    // Clears the byte-lane bits so every bus access is word aligned.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    state_t state;

    assign m_axil.awprot = PROT;
    assign m_axil.arprot = PROT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cmd_ready      <= 1'b0;
            busy           <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_write      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= 2'b00;
            m_axil.awaddr  <= '0;
            m_axil.awvalid <= 1'b0;
            m_axil.wdata   <= '0;
            m_axil.wstrb   <= '0;
            m_axil.wvalid  <= 1'b0;
            m_axil.bready  <= 1'b0;
            m_axil.araddr  <= '0;
            m_axil.arvalid <= 1'b0;
            m_axil.rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_write) begin
                            m_axil.awaddr  <= cmd_addr & ALIGN_MASK;
                            m_axil.wdata   <= cmd_wdata;
                            m_axil.wstrb   <= cmd_wstrb;
                            m_axil.awvalid <= 1'b1;
                            m_axil.wvalid  <= 1'b1;
                            state          <= WR_ADDR_DATA;
                        end else begin
                            m_axil.araddr  <= cmd_addr & ALIGN_MASK;
                            m_axil.arvalid <= 1'b1;
                            state          <= RD_ADDR;
                        end
                    end else begin
                        // First cycle out of reset lands here with cmd_ready low.
                        cmd_ready <= 1'b1;
                    end
                end

                WR_ADDR_DATA: begin
                    if (m_axil.awvalid && m_axil.awready) begin
                        m_axil.awvalid <= 1'b0;
                    end
                    if (m_axil.wvalid && m_axil.wready) begin
                        m_axil.wvalid <= 1'b0;
                    end
                    // A channel is finished if it already dropped or is handshaking now.
                    if ((!m_axil.awvalid || m_axil.awready) &&
                        (!m_axil.wvalid || m_axil.wready)) begin
                        m_axil.bready <= 1'b1;
                        state         <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (m_axil.bvalid && m_axil.bready) begin
                        m_axil.bready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_write     <= 1'b1;
                        rsp_rdata     <= '0;
                        rsp_resp      <= m_axil.bresp;
                        state         <= RSP;
                    end
                end

                RD_ADDR: begin
                    if (m_axil.arvalid && m_axil.arready) begin
                        m_axil.arvalid <= 1'b0;
                        m_axil.rready  <= 1'b1;
                        state          <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (m_axil.rvalid && m_axil.rready) begin
                        m_axil.rready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_write     <= 1'b0;
                        rsp_rdata     <= m_axil.rdata;
                        rsp_resp      <= m_axil.rresp;
                        state         <= RSP;
                    end
                end

                RSP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
